sci_slave_burst: RTL and testbench
==================================

Name: sci_slave_burst

Overview:
- Serial Control Interface (SCI) slave, second generation: converts a bit-serial master request into native-interface (NI) register reads and writes.
- Adds burst transfers with address auto-increment, a configurable burst-length header field, an NI timeout with error signalling, and abort on early chip-select release.
- Sits between the chip-level SCI pins and the local register map. One SCI bit is transferred per CLK.

Parameters:
- ADDR_WIDTH, 8, register address width in bits.
- DATA_WIDTH, 8, register data width in bits.
- BURST_BITS, 2, width of the burst-length header field; a burst is 1..2^BURST_BITS beats.
- TIMEOUT, 15, maximum CLK cycles to wait for NI_WACK or NI_RVALID before error; must be >= 1.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  synchronous, active-low reset.
- SCI_CSN  in  1  chip select, active low, driven by master.
- SCI_REQ  in  1  serial request bits from master.
- SCI_RESP  out  1  serial read data to master.
- SCI_ACK  out  1  beat acknowledge / read-data-valid strobe.
- SCI_ERR  out  1  one-cycle pulse: NI timeout, transaction aborted.
- NI_WREQ  out  1  one-cycle write request.
- NI_WADDR  out  ADDR_WIDTH  write address.
- NI_WDATA  out  DATA_WIDTH  write data.
- NI_WACK  in  1  write acknowledge.
- NI_RREQ  out  1  one-cycle read request.
- NI_RADDR  out  ADDR_WIDTH  read address.
- NI_RDATA  in  DATA_WIDTH  read data.
- NI_RVALID  in  1  read data valid.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Input resampling: SCI_CSN and SCI_REQ are registered once. All decisions use the registered copies csn_q and req_q.
- Open: a falling edge on csn_q (IDLE only) is sampled together with req_q as WnR (1 = write), then IDLE -> HDR.
- HDR state: shifts in BURST_BITS of LEN, then ADDR_WIDTH of address, both MSB-first, one bit per CLK. The burst is LEN+1 beats.
- Write path:
  - HDR -> WDATA. WDATA shifts in DATA_WIDTH bits MSB-first.
  - On the last bit, NI_WREQ pulses in the next cycle with NI_WADDR = current address and NI_WDATA = the shifted word. FSM -> WWAIT.
  - WWAIT, on NI_WACK: SCI_ACK pulses the same cycle (combinational from NI_WACK).
  - If beats remain: address += 1, beat counter decrements, -> WDATA. Otherwise -> IDLE.
- Read path:
  - HDR last bit -> NI_RREQ pulses in the next cycle. FSM -> RWAIT.
  - RWAIT, on NI_RVALID: NI_RDATA is loaded into the PISO. FSM -> RSHIFT.
  - RSHIFT: SCI_RESP drives the MSB first. SCI_ACK is high for exactly DATA_WIDTH cycles, one bit per cycle.
  - After the last bit: if beats remain, address += 1, a new NI_RREQ pulses in the next cycle, -> RWAIT. Otherwise -> IDLE.
- Address wraps modulo 2^ADDR_WIDTH; the burst continues across the wrap.
- Timeout:
  - The counter resets on entry to WWAIT/RWAIT and increments each cycle there.
  - If it reaches TIMEOUT with no WACK/RVALID: SCI_ERR pulses one cycle, -> IDLE, remaining beats dropped.
  - An ack in the same cycle the count reaches TIMEOUT wins; no error is raised.
- Abort: csn_q rising in any non-IDLE state -> IDLE next cycle. No further NI requests are issued. A pending NI ack is ignored. No SCI_ERR.
- NI acks arriving outside WWAIT/RWAIT are ignored.
- A new CSN falling edge is ignored unless the FSM is in IDLE.
- NI_WADDR and NI_RADDR both carry the current address register. NI_WDATA is held stable from the NI_WREQ pulse until the next WDATA shift begins.
- Reset values:
  - All outputs 0: SCI_RESP, SCI_ACK, SCI_ERR, NI_WREQ, NI_RREQ, BUSY, NI_WADDR, NI_WDATA, NI_RADDR.
  - FSM IDLE; counters and shift registers cleared.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values; the partial beat is discarded.
- States: IDLE, HDR, WDATA, WWAIT, RWAIT, RSHIFT.

Test Plan:
- Single write: WnR=1, LEN=0, addr 0x3C, data 0xA5 -> one NI_WREQ with WADDR=0x3C, WDATA=0xA5; WACK after 2 cycles -> single SCI_ACK pulse; BUSY low afterwards.
- Burst read: WnR=0, LEN=3, addr 0xFE, NI returns 0x11/0x22/0x33/0x44 -> RADDR sequence 0xFE, 0xFF, 0x00, 0x01 (wrap); SCI_RESP streams each word MSB-first with SCI_ACK high 8 cycles per beat.
- Timeout: write addr 0x10, WACK never asserted -> SCI_ERR pulses exactly TIMEOUT(15) cycles after WWAIT entry; FSM IDLE; no SCI_ACK.
- Boundary ack: NI_RVALID asserted exactly on timeout cycle 15 -> no SCI_ERR; data 0x5A shifted out.
- Abort: CSN released after the 4th data bit of beat 2 of a LEN=2 write -> only beat 1 NI_WREQ seen; IDLE; next transaction completes normally.
- Reset: RSTN low during RSHIFT of 0xC3 -> next cycle SCI_ACK=0, SCI_RESP=0, BUSY=0; a subsequent read of addr 0x07 works.

Source files
------------

// File: rtl/sci_slave_burst.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sci_slave_burst
// Bit-serial control interface slave. Turns a serial master request into
// native-interface register reads and writes. Supports bursts with address
// auto-increment, an NI response timeout with an error pulse, and abort when
// the master releases chip select early.
//
// Frame on SCI_REQ (one bit per CLK, MSB-first fields):
//   WnR | LEN[BURST_BITS] | ADDR[ADDR_WIDTH] | (write) DATA[DATA_WIDTH] per beat
// A burst is LEN+1 beats. The address wraps modulo 2^ADDR_WIDTH.
// ---------------------------------------------------------------------------
module sci_slave_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_BITS = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  SCI_CSN,
    input  logic                  SCI_REQ,
    output logic                  SCI_RESP,
    output logic                  SCI_ACK,
    output logic                  SCI_ERR,
    output logic                  NI_WREQ,
    output logic [ADDR_WIDTH-1:0] NI_WADDR,
    output logic [DATA_WIDTH-1:0] NI_WDATA,
    input  logic                  NI_WACK,
    output logic                  NI_RREQ,
    output logic [ADDR_WIDTH-1:0] NI_RADDR,
    input  logic [DATA_WIDTH-1:0] NI_RDATA,
    input  logic                  NI_RVALID,
    output logic                  BUSY
);

    // Bit counter must cover the header and one data word.
    localparam int CNT_W = $clog2(BURST_BITS + ADDR_WIDTH + DATA_WIDTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LEN_BITS  = CNT_W'(BURST_BITS);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(BURST_BITS + ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_WWAIT  = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_RSHIFT = 3'd5
    } state_t;

    // Resampled pins and edge history
    logic                  csn_q;
    logic                  csn_dly_q;
    logic                  req_q;

    // FSM state and datapath registers
    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [TMO_W-1:0]      tmo_q,    tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [BURST_BITS-1:0] beat_q,   beat_d;
    logic                  wnr_q,    wnr_d;
    logic [DATA_WIDTH-1:0] wsr_q,    wsr_d;
    logic [DATA_WIDTH-1:0] piso_q,   piso_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  wreq_q,   wreq_d;
    logic                  rreq_q,   rreq_d;

    // Decoded events
    logic                  csn_fall_s;
    logic                  abort_s;
    logic                  tmo_hit_s;
    logic                  wack_s;
    logic                  rvalid_s;
    logic                  err_s;
    logic                  beats_left_s;

    // Edge detection on the registered chip select; abort on release mid-frame.
    always_comb begin
        csn_fall_s   = csn_dly_q & ~csn_q;
        abort_s      = (state_q != ST_IDLE) & csn_q & ~csn_dly_q;
        tmo_hit_s    = (tmo_q == TMO_LIMIT);
        beats_left_s = (beat_q != {BURST_BITS{1'b0}});
        wack_s       = (state_q == ST_WWAIT) & NI_WACK & ~abort_s;
        rvalid_s     = (state_q == ST_RWAIT) & NI_RVALID & ~abort_s;
        // An ack arriving on the limit cycle wins over the timeout.
        err_s        = ~abort_s & tmo_hit_s &
                       (((state_q == ST_WWAIT) & ~NI_WACK) |
                        ((state_q == ST_RWAIT) & ~NI_RVALID));
    end

    // Next-state and datapath updates for the transfer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        wnr_d   = wnr_q;
        wsr_d   = wsr_q;
        piso_d  = piso_q;
        wdata_d = wdata_q;
        wreq_d  = 1'b0;
        rreq_d  = 1'b0;

        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csn_fall_s) begin
                        wnr_d   = req_q;
                        cnt_d   = CNT_W'(0);
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_HDR: begin
                    // Length field first, then the start address.
                    if (cnt_q < LEN_BITS) begin
                        beat_d = BURST_BITS'({beat_q, req_q});
                    end else begin
                        addr_d = ADDR_WIDTH'({addr_q, req_q});
                    end
                    if (cnt_q == HDR_LAST) begin
                        cnt_d = CNT_W'(0);
                        tmo_d = TMO_W'(0);
                        if (wnr_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            rreq_d  = 1'b1;
                            state_d = ST_RWAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_WDATA: begin
                    wsr_d = DATA_WIDTH'({wsr_q, req_q});
                    if (cnt_q == DATA_LAST) begin
                        wdata_d = wsr_d;
                        wreq_d  = 1'b1;
                        tmo_d   = TMO_W'(0);
                        cnt_d   = CNT_W'(0);
                        state_d = ST_WWAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_WWAIT: begin
                    if (NI_WACK) begin
                        if (beats_left_s) begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            beat_d  = beat_q - BURST_BITS'(1);
                            cnt_d   = CNT_W'(0);
                            state_d = ST_WDATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (tmo_hit_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end

                ST_RWAIT: begin
                    if (NI_RVALID) begin
                        piso_d  = NI_RDATA;
                        cnt_d   = CNT_W'(0);
                        state_d = ST_RSHIFT;
                    end else if (tmo_hit_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end

                ST_RSHIFT: begin
                    piso_d = DATA_WIDTH'({piso_q, 1'b0});
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = CNT_W'(0);
                        if (beats_left_s) begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            beat_d  = beat_q - BURST_BITS'(1);
                            tmo_d   = TMO_W'(0);
                            rreq_d  = 1'b1;
                            state_d = ST_RWAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pin resampling, FSM state and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            csn_q     <= 1'b0;
            csn_dly_q <= 1'b0;
            req_q     <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_W'(0);
            tmo_q     <= TMO_W'(0);
            addr_q    <= {ADDR_WIDTH{1'b0}};
            beat_q    <= {BURST_BITS{1'b0}};
            wnr_q     <= 1'b0;
            wsr_q     <= {DATA_WIDTH{1'b0}};
            piso_q    <= {DATA_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wreq_q    <= 1'b0;
            rreq_q    <= 1'b0;
        end else begin
            csn_q     <= SCI_CSN;
            csn_dly_q <= csn_q;
            req_q     <= SCI_REQ;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            wnr_q     <= wnr_d;
            wsr_q     <= wsr_d;
            piso_q    <= piso_d;
            wdata_q   <= wdata_d;
            wreq_q    <= wreq_d;
            rreq_q    <= rreq_d;
        end
    end

    // Output mapping: NI side from registers, SCI acks decoded from state.
    always_comb begin
        NI_WREQ  = wreq_q;
        NI_RREQ  = rreq_q;
        NI_WADDR = addr_q;
        NI_RADDR = addr_q;
        NI_WDATA = wdata_q;
        BUSY     = (state_q != ST_IDLE);
        SCI_ACK  = wack_s | ((state_q == ST_RSHIFT) & ~abort_s);
        SCI_RESP = (state_q == ST_RSHIFT) & ~abort_s & piso_q[DATA_WIDTH-1];
        SCI_ERR  = err_s;
    end

    // rvalid_s is kept as a named decode for the read-side ack path.
    logic unused_s;
    always_comb begin
        unused_s = rvalid_s;
    end

endmodule

// File: tb/tb_sci_slave_burst.sv
`timescale 1ns/1ps
// Scoreboard bench for sci_slave_burst: the serial master and NI responder
// are driven from the main thread with known cycle timing; a monitor on the
// falling edge pops expected NI requests and read words and compares them.
module tb_sci_slave_burst;

    logic       CLK;
    logic       RSTN;
    logic       SCI_CSN;
    logic       SCI_REQ;
    logic       SCI_RESP;
    logic       SCI_ACK;
    logic       SCI_ERR;
    logic       NI_WREQ;
    logic [7:0] NI_WADDR;
    logic [7:0] NI_WDATA;
    logic       NI_WACK;
    logic       NI_RREQ;
    logic [7:0] NI_RADDR;
    logic [7:0] NI_RDATA;
    logic       NI_RVALID;
    logic       BUSY;

    sci_slave_burst #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .BURST_BITS (2),
        .TIMEOUT    (15)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .SCI_CSN   (SCI_CSN),
        .SCI_REQ   (SCI_REQ),
        .SCI_RESP  (SCI_RESP),
        .SCI_ACK   (SCI_ACK),
        .SCI_ERR   (SCI_ERR),
        .NI_WREQ   (NI_WREQ),
        .NI_WADDR  (NI_WADDR),
        .NI_WDATA  (NI_WDATA),
        .NI_WACK   (NI_WACK),
        .NI_RREQ   (NI_RREQ),
        .NI_RADDR  (NI_RADDR),
        .NI_RDATA  (NI_RDATA),
        .NI_RVALID (NI_RVALID),
        .BUSY      (BUSY)
    );

    int n_checks;
    int n_errors;

    logic [15:0] exp_w_q [$];   // {addr, data} of expected write requests
    logic [7:0]  exp_r_q [$];   // expected read-request addresses
    logic [7:0]  exp_d_q [$];   // expected words streamed on SCI_RESP

    int wreq_n, rreq_n, wack_n, err_n, cyc_n;
    int last_wreq_cyc, last_err_cyc;
    int rbit_n;
    logic [7:0] rsr;

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: sample outputs mid-cycle and score them.
    initial begin
        logic [15:0] e16;
        logic [7:0]  e8;
        forever begin
            @(negedge CLK);
            cyc_n++;
            if (!RSTN) begin
                rbit_n = 0;
            end else begin
                if (NI_WREQ) begin
                    wreq_n++;
                    last_wreq_cyc = cyc_n;
                    if (exp_w_q.size() == 0) begin
                        check_eq("wreq_unexpected", 32'd1, 32'd0);
                    end else begin
                        e16 = exp_w_q.pop_front();
                        check_eq("waddr", {24'd0, NI_WADDR}, {24'd0, e16[15:8]});
                        check_eq("wdata", {24'd0, NI_WDATA}, {24'd0, e16[7:0]});
                    end
                end
                if (NI_RREQ) begin
                    rreq_n++;
                    if (exp_r_q.size() == 0) begin
                        check_eq("rreq_unexpected", 32'd1, 32'd0);
                    end else begin
                        e8 = exp_r_q.pop_front();
                        check_eq("raddr", {24'd0, NI_RADDR}, {24'd0, e8});
                    end
                end
                if (SCI_ERR) begin
                    err_n++;
                    last_err_cyc = cyc_n;
                end
                if (SCI_ACK && NI_WACK) begin
                    wack_n++;
                end else if (SCI_ACK) begin
                    rsr = {rsr[6:0], SCI_RESP};
                    rbit_n++;
                    if (rbit_n == 8) begin
                        rbit_n = 0;
                        if (exp_d_q.size() == 0) begin
                            check_eq("resp_unexpected", 32'd1, 32'd0);
                        end else begin
                            e8 = exp_d_q.pop_front();
                            check_eq("resp_word", {24'd0, rsr}, {24'd0, e8});
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        SCI_CSN = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic send_bit(input logic b);
        SCI_REQ = b;
        cyc();
    endtask

    // Serial write; stop_bits >= 0 releases CSN after that many data bits.
    task automatic sci_write(input logic [7:0] addr, input logic [1:0] len,
                             input logic [31:0] wds, input int ack_dly,
                             input bit do_ack, input int stop_bits);
        int sent;
        bit stopped;
        logic [7:0] w;
        sent = 0;
        stopped = 1'b0;
        idle(3);
        SCI_CSN = 1'b0;
        send_bit(1'b1);
        for (int i = 1; i >= 0; i--) send_bit(len[i]);
        for (int i = 7; i >= 0; i--) send_bit(addr[i]);
        for (int b = 0; b <= int'(len) && !stopped; b++) begin
            w = wds[31-8*b -: 8];
            if (stop_bits < 0 || stop_bits >= 8*(b+1))
                exp_w_q.push_back({addr + 8'(b), w});
            for (int i = 7; i >= 0 && !stopped; i--) begin
                if (sent == stop_bits) begin
                    stopped = 1'b1;
                end else begin
                    SCI_REQ = w[i];
                    NI_WACK = (i == 7 && b > 0);
                    cyc();
                    NI_WACK = 1'b0;
                    sent++;
                end
            end
            if (!stopped) begin
                cyc();                       // NI_WREQ cycle
                repeat (ack_dly) cyc();
                if (b == int'(len) && do_ack) begin
                    NI_WACK = 1'b1;
                    cyc();
                    NI_WACK = 1'b0;
                end
            end
        end
        SCI_CSN = 1'b1;
        cyc();
    endtask

    // Serial read; rst_bit >= 0 pulses RSTN during that RSHIFT bit of beat 0.
    task automatic sci_read(input logic [7:0] addr, input logic [1:0] len,
                            input logic [31:0] wds, input int rv_dly,
                            input int rst_bit);
        logic [7:0] w;
        idle(3);
        SCI_CSN = 1'b0;
        send_bit(1'b0);
        for (int i = 1; i >= 0; i--) send_bit(len[i]);
        for (int i = 7; i >= 0; i--) send_bit(addr[i]);
        for (int b = 0; b <= int'(len); b++) exp_r_q.push_back(addr + 8'(b));
        cyc();                               // first NI_RREQ cycle
        for (int b = 0; b <= int'(len); b++) begin
            w = wds[31-8*b -: 8];
            repeat (rv_dly) cyc();
            NI_RVALID = 1'b1;
            NI_RDATA  = w;
            exp_d_q.push_back(w);
            cyc();
            NI_RVALID = 1'b0;
            NI_RDATA  = 8'h00;
            if (rst_bit >= 0) begin
                repeat (rst_bit) cyc();
                RSTN = 1'b0;
                cyc();
                RSTN = 1'b1;
                check_eq("rst_mid_ack",   {31'd0, SCI_ACK},  32'd0);
                check_eq("rst_mid_resp",  {31'd0, SCI_RESP}, 32'd0);
                check_eq("rst_mid_busy",  {31'd0, BUSY},     32'd0);
                check_eq("rst_mid_raddr", {24'd0, NI_RADDR}, 32'd0);
                exp_d_q.delete();
                return;
            end
            repeat (8) cyc();
        end
        SCI_CSN = 1'b1;
        cyc();
    endtask

    // Hard stop in case anything stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Main stimulus sequence.
    initial begin
        int w0, r0, a0, e0;
        n_checks = 0; n_errors = 0;
        wreq_n = 0; rreq_n = 0; wack_n = 0; err_n = 0; cyc_n = 0;
        last_wreq_cyc = 0; last_err_cyc = 0; rbit_n = 0; rsr = 8'h00;
        RSTN = 1'b0; SCI_CSN = 1'b1; SCI_REQ = 1'b0;
        NI_WACK = 1'b0; NI_RVALID = 1'b0; NI_RDATA = 8'h00;

        repeat (4) cyc();
        check_eq("rst_busy",  {31'd0, BUSY},     32'd0);
        check_eq("rst_ack",   {31'd0, SCI_ACK},  32'd0);
        check_eq("rst_err",   {31'd0, SCI_ERR},  32'd0);
        check_eq("rst_resp",  {31'd0, SCI_RESP}, 32'd0);
        check_eq("rst_wreq",  {31'd0, NI_WREQ},  32'd0);
        check_eq("rst_rreq",  {31'd0, NI_RREQ},  32'd0);
        check_eq("rst_waddr", {24'd0, NI_WADDR}, 32'd0);
        check_eq("rst_wdata", {24'd0, NI_WDATA}, 32'd0);
        RSTN = 1'b1;
        idle(3);

        // Single write, WACK two cycles after the request
        w0 = wreq_n; a0 = wack_n; e0 = err_n;
        sci_write(8'h3C, 2'd0, 32'hA500_0000, 2, 1'b1, -1);
        check_eq("sw_wreq_cnt", 32'(wreq_n - w0), 32'd1);
        check_eq("sw_ack_cnt",  32'(wack_n - a0), 32'd1);
        check_eq("sw_err_cnt",  32'(err_n - e0),  32'd0);
        check_eq("sw_busy",     {31'd0, BUSY},    32'd0);

        // Four-beat read across the address wrap
        r0 = rreq_n; e0 = err_n;
        sci_read(8'hFE, 2'd3, 32'h1122_3344, 2, -1);
        check_eq("br_rreq_cnt", 32'(rreq_n - r0), 32'd4);
        check_eq("br_err_cnt",  32'(err_n - e0),  32'd0);
        check_eq("br_busy",     {31'd0, BUSY},    32'd0);

        // Write timeout: WACK never arrives
        a0 = wack_n; e0 = err_n;
        sci_write(8'h10, 2'd0, 32'h7700_0000, 20, 1'b0, -1);
        check_eq("to_err_cnt", 32'(err_n - e0), 32'd1);
        check_eq("to_err_lat", 32'(last_err_cyc - last_wreq_cyc), 32'd15);
        check_eq("to_ack_cnt", 32'(wack_n - a0), 32'd0);
        check_eq("to_busy",    {31'd0, BUSY},    32'd0);

        // RVALID on the limit cycle wins over the timeout
        e0 = err_n;
        sci_read(8'h20, 2'd0, 32'h5A00_0000, 15, -1);
        check_eq("bd_err_cnt", 32'(err_n - e0), 32'd0);
        check_eq("bd_busy",    {31'd0, BUSY},   32'd0);

        // Abort after 4 data bits of beat 2 of a 3-beat write
        w0 = wreq_n; a0 = wack_n; e0 = err_n;
        sci_write(8'h80, 2'd2, 32'h0102_0300, 1, 1'b1, 12);
        idle(3);
        check_eq("ab_wreq_cnt", 32'(wreq_n - w0), 32'd1);
        check_eq("ab_ack_cnt",  32'(wack_n - a0), 32'd1);
        check_eq("ab_err_cnt",  32'(err_n - e0),  32'd0);
        check_eq("ab_busy",     {31'd0, BUSY},    32'd0);

        // Follow-up two-beat write across the wrap, ack in the request cycle
        w0 = wreq_n; a0 = wack_n;
        sci_write(8'hFF, 2'd1, 32'hDEBE_0000, 0, 1'b1, -1);
        check_eq("fw_wreq_cnt", 32'(wreq_n - w0), 32'd2);
        check_eq("fw_ack_cnt",  32'(wack_n - a0), 32'd2);
        check_eq("fw_busy",     {31'd0, BUSY},    32'd0);

        // NI acks in IDLE are ignored
        a0 = wack_n;
        idle(2);
        NI_WACK = 1'b1; NI_RVALID = 1'b1;
        cyc();
        NI_WACK = 1'b0; NI_RVALID = 1'b0;
        cyc();
        check_eq("stray_ack_cnt", 32'(wack_n - a0), 32'd0);
        check_eq("stray_rbits",   32'(rbit_n),      32'd0);
        check_eq("stray_busy",    {31'd0, BUSY},    32'd0);

        // Reset in the middle of shifting 0xC3, then a clean read of 0x07
        sci_read(8'h40, 2'd0, 32'hC300_0000, 3, 5);
        r0 = rreq_n;
        sci_read(8'h07, 2'd0, 32'h9600_0000, 4, -1);
        check_eq("pr_rreq_cnt", 32'(rreq_n - r0), 32'd1);
        check_eq("pr_busy",     {31'd0, BUSY},    32'd0);

        idle(4);
        check_eq("left_w",     32'(exp_w_q.size()), 32'd0);
        check_eq("left_r",     32'(exp_r_q.size()), 32'd0);
        check_eq("left_d",     32'(exp_d_q.size()), 32'd0);
        check_eq("left_rbits", 32'(rbit_n),         32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
